// File: rtl/lms_pad_multichannel.sv
// Time-multiplexed LMS sin/cos fit for N_CH channels sharing one DDS reference.
// Define LMS_PAD_AM2_EN to build the a^2+b^2 output; otherwise it is tied to 0.
module lms_pad_multichannel #(
  parameter int N_CH           = 4,
  parameter int SC_Q_WIDTH     = 24,
  parameter int LMS_DATA_WIDTH = 26,
  parameter int LMS_Q_WIDTH    = 22,
  parameter int CH_W = ($clog2(N_CH) > 0) ? $clog2(N_CH) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [32*N_CH-1:0] S_AXIS_SIGNAL_tdata,
  input  logic              S_AXIS_SIGNAL_tvalid,
  output logic              S_AXIS_SIGNAL_tready,
  input  logic [63:0]       S_AXIS_SC_tdata,
  input  logic [31:0]       tau,
  input  logic              lms_clear,
  output logic [63:0]       M_AXIS_XY_tdata,
  output logic [CH_W-1:0]   M_AXIS_XY_tuser,
  output logic              M_AXIS_XY_tvalid,
  input  logic              M_AXIS_XY_tready,
  output logic [47:0]       M_AXIS_AM2_tdata
);

  localparam int DW  = LMS_DATA_WIDTH;
  localparam int SW  = SC_Q_WIDTH + 1;
  localparam int PW  = DW + 2;
  localparam int MW  = 32 + PW - LMS_Q_WIDTH;
  localparam int UW  = MW + SW - SC_Q_WIDTH;
  localparam int AW  = UW + 1;
  localparam int PSW = DW + SW + 1;
  localparam int TW  = 32 + PW;
  localparam int DSW = MW + SW;

  localparam logic signed [AW-1:0] LIM =
    AW'((1 << (DW-1)) - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]             r_state;
  logic [CH_W-1:0]        r_ch;
  logic signed [DW-1:0]   r_a [N_CH];
  logic signed [DW-1:0]   r_b [N_CH];
  logic signed [DW-1:0]   r_x [N_CH];
  logic signed [SW-1:0]   r_s;
  logic signed [SW-1:0]   r_c;
  logic signed [31:0]     r_tau;
  logic signed [PW-1:0]   r_p;
  logic signed [MW-1:0]   r_m;
  logic [63:0]            r_xy;
  logic [CH_W-1:0]        r_tuser;
  logic                   r_tvalid;

  logic signed [DW-1:0]   w_a_cur;
  logic signed [DW-1:0]   w_b_cur;
  logic signed [DW-1:0]   w_x_cur;
  logic signed [PW-1:0]   w_p;
  logic signed [PW-1:0]   w_e;
  logic signed [MW-1:0]   w_m;
  logic signed [UW-1:0]   w_da;
  logic signed [UW-1:0]   w_db;
  logic signed [DW-1:0]   w_a_new;
  logic signed [DW-1:0]   w_b_new;

  function automatic logic signed [DW-1:0] f_sat(
    input logic signed [AW-1:0] v
  );
    if (v > LIM)       f_sat = DW'(LIM);
    else if (v < -LIM) f_sat = DW'(-LIM);
    else               f_sat = DW'(v);
  endfunction

  assign w_a_cur = r_a[r_ch];
  assign w_b_cur = r_b[r_ch];
  assign w_x_cur = r_x[r_ch];

  assign w_p = PW'((PSW'(w_a_cur) * PSW'(r_s)
                  + PSW'(w_b_cur) * PSW'(r_c))
                  >>> SC_Q_WIDTH);
  assign w_e = PW'(w_x_cur) - r_p;
  assign w_m = MW'((TW'(r_tau) * TW'(w_e))
                  >>> LMS_Q_WIDTH);

  assign w_da = UW'((DSW'(r_m) * DSW'(r_s))
                   >>> SC_Q_WIDTH);
  assign w_db = UW'((DSW'(r_m) * DSW'(r_c))
                   >>> SC_Q_WIDTH);
  assign w_a_new = f_sat(AW'(w_a_cur) + AW'(w_da));
  assign w_b_new = f_sat(AW'(w_b_cur) + AW'(w_db));

  // Only the low DW / SW bits of each input slot carry data.
  logic [N_CH*(32-DW)-1:0] w_unused_hi;
  for (genvar k = 0; k < N_CH; k++) begin : g_hi
    assign w_unused_hi[k*(32-DW) +: (32-DW)] =
      S_AXIS_SIGNAL_tdata[32*k+DW +: (32-DW)];
  end
  logic w_unused;
  assign w_unused = ^{w_unused_hi,
                      S_AXIS_SC_tdata[63:32+SW],
                      S_AXIS_SC_tdata[31:SW]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_s      <= '0;
      r_c      <= '0;
      r_tau    <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_xy     <= '0;
      r_tuser  <= '0;
      r_tvalid <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_x[k] <= '0;
      end
    end else if (lms_clear) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_xy     <= '0;
      r_tuser  <= '0;
      r_tvalid <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (S_AXIS_SIGNAL_tvalid) begin
            for (int k = 0; k < N_CH; k++)
              r_x[k] <= S_AXIS_SIGNAL_tdata[32*k +: DW];
            r_s     <= S_AXIS_SC_tdata[32 +: SW];
            r_c     <= S_AXIS_SC_tdata[0 +: SW];
            r_tau   <= tau;
            r_ch    <= '0;
            r_state <= S_P0;
          end
        end
        S_P0: begin
          r_p     <= w_p;
          r_state <= S_P1;
        end
        S_P1: begin
          r_m     <= w_m;
          r_state <= S_P2;
        end
        S_P2: begin
          r_a[r_ch] <= w_a_new;
          r_b[r_ch] <= w_b_new;
          r_xy      <= {32'(w_a_new), 32'(w_b_new)};
          r_tuser   <= r_ch;
          r_tvalid  <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (M_AXIS_XY_tready) begin
            r_tvalid <= 1'b0;
            if (r_ch == CH_W'(N_CH-1)) begin
              r_state <= S_IDLE;
            end else begin
              r_ch    <= r_ch + 1'b1;
              r_state <= S_P0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LMS_PAD_AM2_EN
  localparam int QW = 2*DW + 1;
  logic [47:0] r_am2;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_am2 <= '0;
    else if (lms_clear)
      r_am2 <= '0;
    else if (r_state == S_P2)
      r_am2 <= 48'(QW'(w_a_new) * QW'(w_a_new)
                 + QW'(w_b_new) * QW'(w_b_new));
  end
  assign M_AXIS_AM2_tdata = r_am2;
`else
  assign M_AXIS_AM2_tdata = '0;
`endif

  assign S_AXIS_SIGNAL_tready = (r_state == S_IDLE);
  assign M_AXIS_XY_tdata      = r_xy;
  assign M_AXIS_XY_tuser      = r_tuser;
  assign M_AXIS_XY_tvalid     = r_tvalid;

endmodule

// File: tb/tb_lms_pad_multichannel.sv
// Randomized bench for lms_pad_multichannel against an arithmetic LMS model.
// Build with or without LMS_PAD_AM2_EN; the AM2 expectation follows the macro.
module tb_lms_pad_multichannel;

  localparam int N  = 4;
  localparam int CW = 2;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [32*N-1:0] sig_d = '0;
  logic            sig_v = 1'b0;
  logic            sig_r;
  logic [63:0]     sc_d = '0;
  logic [31:0]     tau_d = '0;
  logic            clr = 1'b0;
  logic [63:0]     xy;
  logic [CW-1:0]   xy_u;
  logic            xy_v;
  logic            xy_r = 1'b1;
  logic [47:0]     am2;

  int n_chk = 0;
  int n_fail = 0;

  longint fx [N];
  longint fs, fc, ftau;
  longint ma [N];
  longint mb [N];
  logic [63:0] first_xy;

  always #5 aclk = ~aclk;

  lms_pad_multichannel #(.N_CH(N)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .S_AXIS_SIGNAL_tdata  (sig_d),
    .S_AXIS_SIGNAL_tvalid (sig_v),
    .S_AXIS_SIGNAL_tready (sig_r),
    .S_AXIS_SC_tdata      (sc_d),
    .tau                  (tau_d),
    .lms_clear            (clr),
    .M_AXIS_XY_tdata      (xy),
    .M_AXIS_XY_tuser      (xy_u),
    .M_AXIS_XY_tvalid     (xy_v),
    .M_AXIS_XY_tready     (xy_r),
    .M_AXIS_AM2_tdata     (am2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint v,
                                input int w);
    longint m = (longint'(1) << w) - 1;
    v = v & m;
    if (((v >> (w-1)) & 1) != 0)
      v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic longint sat(input longint v);
    longint lim = (longint'(1) << 25) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic zero_model();
    for (int k = 0; k < N; k++) begin
      ma[k] = 0;
      mb[k] = 0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++)
      sig_d[32*k +: 32] = 32'(fx[k]);
    sc_d  = {32'(fs), 32'(fc)};
    tau_d = 32'(ftau);
  endtask

  task automatic load_rand();
    for (int k = 0; k < N; k++)
      fx[k] = sx(longint'($urandom), 26);
    fs   = sx(longint'($urandom), 25);
    fc   = sx(longint'($urandom), 25);
    ftau = longint'($urandom_range(0, 1 << 23))
         - (longint'(1) << 20);
    drive();
  endtask

  task automatic load_fix(input longint x,
                          input longint s,
                          input longint c,
                          input longint t);
    for (int k = 0; k < N; k++) fx[k] = x;
    fs = s;
    fc = c;
    ftau = t;
    drive();
  endtask

  task automatic model_ch(input int k);
    longint p, e, m;
    p = (ma[k] * fs + mb[k] * fc) >>> 24;
    e = fx[k] - p;
    m = (ftau * e) >>> 22;
    ma[k] = sat(ma[k] + ((m * fs) >>> 24));
    mb[k] = sat(mb[k] + ((m * fc) >>> 24));
  endtask

  task automatic accept();
    chk("in_ready", 64'(sig_r), 64'd1);
    sig_v = 1'b1;
    tick();
    sig_v = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!xy_v && n < 20) begin
      tick();
      n++;
    end
    chk("tvalid", 64'(xy_v), 64'd1);
  endtask

  task automatic check_out(input int k);
    longint q;
    model_ch(k);
    chk("xy", xy, {32'(ma[k]), 32'(mb[k])});
    chk("tuser", 64'(xy_u), 64'(k));
    q = (ma[k] * ma[k] + mb[k] * mb[k])
        & longint'(48'hFFFF_FFFF_FFFF);
`ifdef LMS_PAD_AM2_EN
    chk("am2", 64'(am2), 64'(q));
`else
    chk("am2", 64'(am2), 64'd0);
`endif
  endtask

  task automatic frame(input int bp_k,
                       output int cyc);
    int n;
    logic [63:0] hold;
    accept();
    cyc = 0;
    for (int k = 0; k < N; k++) begin
      wait_valid(n);
      cyc += n;
      check_out(k);
      if (k == 0) first_xy = xy;
      if (k == bp_k) begin
        xy_r = 1'b0;
        hold = xy;
        repeat (10) begin
          tick();
          cyc++;
          chk("bp_valid", 64'(xy_v), 64'd1);
          chk("bp_data", xy, hold);
          chk("bp_inrdy", 64'(sig_r), 64'd0);
        end
        xy_r = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("idle", 64'(sig_r), 64'd1);
  endtask

  initial begin
    int cyc, n;
    repeat (3) tick();
    chk("rst_inrdy", 64'(sig_r), 64'd1);
    chk("rst_valid", 64'(xy_v), 64'd0);
    chk("rst_xy", xy, 64'd0);
    chk("rst_tuser", 64'(xy_u), 64'd0);
    chk("rst_am2", 64'(am2), 64'd0);
    aresetn = 1'b1;
    tick();
    zero_model();

    for (int f = 0; f < 6; f++) begin
      load_rand();
      frame((f == 2) ? 1 : -1, cyc);
      chk("frame_cyc", 64'(cyc),
          64'(4*N + ((f == 2) ? 10 : 0)));
    end

    load_rand();
    ftau = 0;
    drive();
    frame(-1, cyc);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    zero_model();
    load_fix(33554431, 16777215, 16777215, 1 << 24);
    frame(-1, cyc);
    chk("sat_pos", first_xy,
        {32'd33554431, 32'd33554431});
    load_fix(-33554432, 16777215, 16777215, 1 << 24);
    frame(-1, cyc);
    chk("sat_neg", first_xy,
        {32'hFE00_0001, 32'hFE00_0001});

    load_rand();
    frame(-1, cyc);
    load_rand();
    accept();
    for (int k = 0; k < 2; k++) begin
      wait_valid(n);
      check_out(k);
      tick();
    end
    wait_valid(n);
    check_out(2);
    xy_r = 1'b0;
    clr  = 1'b1;
    tick();
    clr  = 1'b0;
    xy_r = 1'b1;
    zero_model();
    chk("clr_valid", 64'(xy_v), 64'd0);
    chk("clr_idle", 64'(sig_r), 64'd1);
    chk("clr_xy", xy, 64'd0);
    frame(-1, cyc);

    load_rand();
    sig_v = 1'b1;
    clr   = 1'b1;
    tick();
    sig_v = 1'b0;
    clr   = 1'b0;
    zero_model();
    chk("clrhs_idle", 64'(sig_r), 64'd1);
    repeat (6) tick();
    chk("clrhs_novalid", 64'(xy_v), 64'd0);
    frame(-1, cyc);

    load_rand();
    frame(-1, cyc);
    load_rand();
    accept();
    tick();
    tick();
    #1 aresetn = 1'b0;
    #1;
    chk("arst_inrdy", 64'(sig_r), 64'd1);
    chk("arst_valid", 64'(xy_v), 64'd0);
    chk("arst_xy", xy, 64'd0);
    tick();
    aresetn = 1'b1;
    zero_model();
    load_rand();
    frame(-1, cyc);
    chk("arst_cyc", 64'(cyc), 64'(4*N));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
